// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and helpers for the GCD scheduler
// Purpose: FSM state encoding, default operand width and the requester-id width helper.
// Ports: none (package).
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } gcd_state_t;

  // Width of a requester index; never below one bit so N=1 still yields a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_core.sv
// rtl/gcd_core.sv - iterative subtractive GCD engine, one step per cycle
// Purpose: loads an operand pair on start and subtracts until a terminal condition.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   start        load x/y and begin iterating
//   x, y         operands (W bits)
//   done         high in the step that reaches a terminal condition
//   result       GCD value, meaningful while done is high
module gcd_core
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         done,
  output logic [W-1:0] result
);

  logic [W-1:0] u_q, u_d;
  logic [W-1:0] v_q, v_d;
  logic         run_q, run_d;
  logic         stop;

  always_comb begin
    stop   = (u_q == '0) || (v_q == '0) || (u_q == v_q);
    done   = run_q && stop;
    // With u==0 the answer is v; in every other terminal case u already holds it.
    result = (u_q == '0) ? v_q : u_q;
    u_d    = u_q;
    v_d    = v_q;
    run_d  = run_q;
    if (start) begin
      u_d   = x;
      v_d   = y;
      run_d = 1'b1;
    end else if (run_q) begin
      if (stop) begin
        run_d = 1'b0;
      end else if (u_q > v_q) begin
        u_d = u_q - v_q;
      end else begin
        v_d = v_q - u_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u_q   <= '0;
      v_q   <= '0;
      run_q <= 1'b0;
    end else begin
      u_q   <= u_d;
      v_q   <= v_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin scheduler sharing one GCD engine among N requesters
// Purpose: grants one requester at a time, runs the engine, holds the result until accepted.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_x, req_y         packed operands, slice i = [i*W +: W]
//   rsp_valid/rsp_ready  response handshake
//   rsp_gcd, rsp_id      result and index of the requester it belongs to
//   busy                 high while the engine runs or a result is held
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = GCD_W,
  localparam int IW = id_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_x,
  input  logic [N*W-1:0] req_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_gcd,
  output logic [IW-1:0]  rsp_id,
  output logic           busy
);

  gcd_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  gcd_q, gcd_d;

  logic          found;
  logic [IW-1:0] pick;
  int            idx;
  logic          core_start;
  logic          core_done;
  logic [W-1:0]  core_result;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    gcd_d      = gcd_q;
    req_ready  = '0;
    core_start = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so no grant is offered while reset is being applied.
        if (found && rst_n) begin
          req_ready[pick] = 1'b1;
          core_start      = 1'b1;
          id_d            = pick;
          ptr_d           = IW'((int'(pick) + 1) % N);
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (core_done) begin
          gcd_d   = core_result;
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here, not granting, yields the one-cycle bubble.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gcd_q   <= gcd_d;
    end
  end

  gcd_core #(
    .W(W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .x     (req_x[int'(pick)*W +: W]),
    .y     (req_y[int'(pick)*W +: W]),
    .done  (core_done),
    .result(core_result)
  );

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_gcd   = gcd_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb/tb_gcd_scheduler.sv - randomized scoreboard bench for gcd_scheduler
module tb_gcd_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_gcd;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  gcd_scheduler #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_gcd  (rsp_gcd),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int gcd;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   qx[N][$];
  int   qy[N][$];
  int   errors = 0;
  int   checks = 0;
  int   rsp_mode = 0;  // 0 always ready, 1 random, 2 hold off 10 cycles
  int   bp_cnt = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtraction count equals the sum of Euclid quotients minus the final equal-operands step.
  function automatic int ref_steps(input int a, input int b);
    int k, t;
    k = 0;
    if (a == 0 || b == 0) return 0;
    while (b != 0) begin
      k += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return k - 1;
  endfunction

  task automatic monitor_loop();
    int            model_ptr, pick, id;
    bit            exp_busy, pv, pr;
    logic [W-1:0]  pg;
    logic [IW-1:0] pid;
    logic [N-1:0]  er, hs;
    exp_t          e;
    model_ptr = 0; exp_busy = 0; pv = 0; pr = 0; pg = '0; pid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_ptr = 0;
        exp_busy  = 0;
        pv        = 0;
        pr        = 0;
        exp_q.delete();
        continue;
      end
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(model_ptr + k) % N]) pick = (model_ptr + k) % N;
      er = '0;
      if (pick >= 0) er[pick] = 1'b1;
      chk(busy == exp_busy, "busy", int'(busy), int'(exp_busy));
      if (exp_busy) chk(req_ready == '0, "ready_while_busy", int'(req_ready), 0);
      else          chk(req_ready == er, "grant", int'(req_ready), int'(er));
      hs = req_valid & req_ready;
      if (hs != '0) begin
        id = 0;
        for (int k = 0; k < N; k++) if (hs[k]) id = k;
        e.id  = id;
        e.gcd = ref_gcd(int'(req_x[id*W +: W]), int'(req_y[id*W +: W]));
        e.t   = cyc + ref_steps(int'(req_x[id*W +: W]), int'(req_y[id*W +: W])) + 2;
        exp_q.push_back(e);
        grant_log.push_back(id);
        model_ptr = (id + 1) % N;
        exp_busy  = 1;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "stale_rsp", int'(rsp_gcd), -1);
        end else begin
          if (!pv)      chk(cyc == exp_q[0].t, "rsp_latency", cyc, exp_q[0].t);
          else if (!pr) chk(rsp_gcd == pg && rsp_id == pid, "rsp_stable",
                            int'({rsp_id, rsp_gcd}), int'({pid, pg}));
          if (rsp_ready) begin
            e = exp_q.pop_front();
            chk(int'(rsp_gcd) == e.gcd, "rsp_gcd", int'(rsp_gcd), e.gcd);
            chk(int'(rsp_id) == e.id, "rsp_id", int'(rsp_id), e.id);
            exp_busy = 0;
          end
        end
      end
      pv = rsp_valid;
      pr = rsp_ready;
      pg = rsp_gcd;
      pid = rsp_id;
    end
  endtask

  // One cycle of requester and consumer behaviour; ends #1 after the rising edge.
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && qx[i].size() > 0) begin
        req_x[i*W +: W] = W'(qx[i].pop_front());
        req_y[i*W +: W] = W'(qy[i].pop_front());
        req_valid[i]    = 1'b1;
      end
    end
    case (rsp_mode)
      1: rsp_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (rsp_valid) begin
          rsp_ready = (bp_cnt >= 10);
          bp_cnt++;
        end else begin
          bp_cnt    = 0;
          rsp_ready = 1'b0;
        end
      end
      default: rsp_ready = 1'b1;
    endcase
  endtask

  task automatic push_job(input int i, input int x, input int y);
    qx[i].push_back(x);
    qy[i].push_back(y);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (qx[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() || req_valid != '0 || exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk(n < budget, "drain_timeout", n, budget);
  endtask

  task automatic reset_outputs_check();
    chk(req_ready == '0, "rst_req_ready", int'(req_ready), 0);
    chk(rsp_valid == 1'b0, "rst_rsp_valid", int'(rsp_valid), 0);
    chk(rsp_gcd == '0, "rst_rsp_gcd", int'(rsp_gcd), 0);
    chk(rsp_id == '0, "rst_rsp_id", int'(rsp_id), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
  endtask

  initial begin
    int base;
    int exp_order[5];
    fork
      monitor_loop();
    join_none
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;

    // Arbitration: all four requesters valid from reset.
    base = grant_log.size();
    push_job(0, 48, 36);
    push_job(1, 17, 17);
    push_job(2, 12, 18);
    push_job(3, 25, 10);
    push_job(0, 9, 6);
    repeat (3) step();
    reset_outputs_check();
    rst_n = 1'b1;
    drain(3000);
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      chk(grant_log.size() > base + k && grant_log[base + k] == exp_order[k], "grant_order",
          (grant_log.size() > base + k) ? grant_log[base + k] : -1, exp_order[k]);

    // Zero operands and the worst-case pair.
    push_job(1, 0, 9);
    push_job(1, 7, 0);
    push_job(1, 0, 0);
    push_job(3, 1, 255);
    push_job(2, 255, 1);
    drain(3000);

    // Back-pressure with a competing requester waiting.
    rsp_mode = 2;
    push_job(0, 30, 12);
    push_job(2, 21, 14);
    drain(3000);

    // Random traffic with random consumer stalls.
    rsp_mode = 1;
    for (int j = 0; j < 24; j++) begin
      if (j % 3 == 0) push_job($urandom_range(0, N - 1), $urandom_range(0, 255), $urandom_range(0, 255));
      else            push_job($urandom_range(0, N - 1), $urandom_range(0, 40), $urandom_range(0, 40));
    end
    drain(20000);

    // Reset in the middle of a long computation.
    rsp_mode = 0;
    push_job(2, 1, 255);
    repeat (60) step();
    chk(busy == 1'b1, "busy_before_reset", int'(busy), 1);
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    step();
    reset_outputs_check();
    base = grant_log.size();
    push_job(0, 10, 4);
    push_job(3, 6, 9);
    step();
    rst_n = 1'b1;
    drain(2000);
    chk(grant_log.size() > base && grant_log[base] == 0, "post_reset_grant",
        (grant_log.size() > base) ? grant_log[base] : -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
